memory_stage: RTL and testbench

- Memory stage of the 5-stage in-order pipeline. Sits between Execute (upstream, EM_BUS) and Writeback (downstream, MW_BUS).
- Waits for the data-SRAM response of loads already issued by Execute, then aligns and extends the load data.
- Forms final_result and forwards the result to Decode.
- Drops SRAM responses that belong to instructions flushed by an exception.

---
 rtl/memory_stage_pkg.sv | 55 +++++
 rtl/memory_stage_load_align.sv | 42 ++++
 rtl/memory_stage.sv | 147 ++++++++++++++
 tb/tb_memory_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: bus field widths, bus layouts
// and load mem_type codes.
package memory_stage_pkg;

    localparam int unsigned PB_WID    = 38;
    localparam int unsigned CSR_WID   = 79;
    localparam int unsigned DCNT_WID  = 2;
    localparam int unsigned ECODE_WID = 8;
    localparam int unsigned ESUB_WID  = 1;
    localparam int unsigned DEST_WID  = 5;
    localparam int unsigned MTYPE_WID = 3;

    localparam int unsigned EM_WID    = PB_WID + CSR_WID + 86;
    localparam int unsigned MW_WID    = PB_WID + CSR_WID + 112;
    localparam int unsigned MFWD_WID  = 38;

    localparam logic [MTYPE_WID-1:0] LD_B  = 3'd0;
    localparam logic [MTYPE_WID-1:0] LD_H  = 3'd1;
    localparam logic [MTYPE_WID-1:0] LD_W  = 3'd2;
    localparam logic [MTYPE_WID-1:0] LD_BU = 3'd4;
    localparam logic [MTYPE_WID-1:0] LD_HU = 3'd5;

    // Execute -> Memory payload. The listed fields fill 85 bits of the
    // 86-bit bus; the top bit is zero-extension from Execute's concatenation.
    typedef struct packed {
        logic                  rsvd;
        logic [PB_WID-1:0]     pb;
        logic [31:0]           pc;
        logic [31:0]           alu_result;
        logic                  gr_we;
        logic [DEST_WID-1:0]   dest;
        logic                  mem_re;
        logic [MTYPE_WID-1:0]  mem_type;
        logic                  req_sent;
        logic                  ex;
        logic [ECODE_WID-1:0]  ecode;
        logic [ESUB_WID-1:0]   esubcode;
        logic [CSR_WID-1:0]    csr;
    } em_bus_t;

    // Memory -> Writeback payload.
    typedef struct packed {
        logic [PB_WID-1:0]     pb;
        logic [31:0]           pc;
        logic [31:0]           final_result;
        logic                  gr_we;
        logic [DEST_WID-1:0]   dest;
        logic [31:0]           vaddr;
        logic                  ex;
        logic [ECODE_WID-1:0]  ecode;
        logic [ESUB_WID-1:0]   esubcode;
        logic [CSR_WID-1:0]    csr;
    } mw_bus_t;

endpackage

// File: rtl/memory_stage_load_align.sv
// Load data alignment and sign/zero extension.
// Ports: mem_type - load kind, sel - address low bits,
//        data - raw 32-bit SRAM word, result - aligned 32-bit value.
module memory_stage_load_align
    import memory_stage_pkg::*;
(
    input  logic [MTYPE_WID-1:0] mem_type,
    input  logic [1:0]           sel,
    input  logic [31:0]          data,
    output logic [31:0]          result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select
    always_comb begin
        byte_sel = data[7:0];
        case (sel)
            2'd0: byte_sel = data[7:0];
            2'd1: byte_sel = data[15:8];
            2'd2: byte_sel = data[23:16];
            2'd3: byte_sel = data[31:24];
            default: byte_sel = data[7:0];
        endcase
        half_sel = sel[1] ? data[31:16] : data[15:0];
    end

    // Extension; unknown encodings behave as a full word
    always_comb begin
        result = data;
        case (mem_type)
            LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LD_H:    result = {{16{half_sel[15]}}, half_sel};
            LD_W:    result = data;
            LD_BU:   result = {24'd0, byte_sel};
            LD_HU:   result = {16'd0, half_sel};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage in-order pipeline: waits for data-SRAM load
// responses, aligns load data, forms final_result, forwards to Decode and
// discards responses owed to flushed loads.
// Ports: clk/rstn; EM_valid/EM_BUS/M_allowin from Execute; MW_valid/MW_BUS/
// W_allowin to Writeback; data_sram_data_ok/rdata load response; ex_en flush;
// Mfwd_BUS forward to Decode; M_load_pending load in flight.
// Optional: define MEM_PERF_CNT_EN to add load_stall_cnt (stall cycle count).
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    input  logic                EM_valid,
    input  logic [EM_WID-1:0]   EM_BUS,
    output logic                M_allowin,
    output logic                MW_valid,
    output logic [MW_WID-1:0]   MW_BUS,
    input  logic                W_allowin,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ex_en,
    output logic [MFWD_WID-1:0] Mfwd_BUS,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0]         load_stall_cnt,
`endif
    output logic                M_load_pending
);

    em_bus_t             em_in;
    em_bus_t             em_q;
    mw_bus_t             mw;
    logic                m_valid;
    logic [31:0]         rdata_buf;
    logic                data_have;
    logic [DCNT_WID-1:0] dcnt;
    logic                dcnt_zero;
    logic                m_ready_go;
    logic                capture;
    logic                dcnt_inc;
    logic                dcnt_dec;
    logic [31:0]         ld_data;
    logic [31:0]         aligned;
    logic [31:0]         final_result;
    logic                unused_bits;

    assign em_in       = em_bus_t'(EM_BUS);
    assign unused_bits = em_q.rsvd;

    // Handshake
    assign dcnt_zero  = (dcnt == '0);
    assign m_ready_go = !em_q.mem_re || em_q.ex || !em_q.req_sent || data_have
                        || (data_sram_data_ok && dcnt_zero);
    assign M_allowin  = !m_valid || (m_ready_go && W_allowin);
    assign MW_valid   = m_valid && m_ready_go;

    assign M_load_pending = m_valid && em_q.mem_re && em_q.req_sent && !data_have;

    // A response with dcnt!=0 belongs to an older, flushed load
    assign capture  = M_load_pending && data_sram_data_ok && dcnt_zero;
    assign dcnt_inc = ex_en && M_load_pending && !(data_sram_data_ok && dcnt_zero);
    assign dcnt_dec = data_sram_data_ok && !dcnt_zero;

    // Pipeline register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            em_q    <= '0;
        end else if (ex_en) begin
            m_valid <= 1'b0;
            em_q    <= '0;
        end else if (M_allowin) begin
            m_valid <= EM_valid;
            if (EM_valid) begin
                em_q <= em_in;
            end
        end
    end

    // Response buffer for data that arrives while Writeback is stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_buf <= '0;
            data_have <= 1'b0;
        end else begin
            if (capture) begin
                rdata_buf <= data_sram_rdata;
            end
            if (ex_en || M_allowin) begin
                data_have <= 1'b0;
            end else if (capture) begin
                data_have <= 1'b1;
            end
        end
    end

    // Outstanding responses still owed to flushed loads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
        end else if (dcnt_inc && !dcnt_dec) begin
            dcnt <= dcnt + DCNT_WID'(1);
        end else if (dcnt_dec && !dcnt_inc) begin
            dcnt <= dcnt - DCNT_WID'(1);
        end
    end

    // Same-cycle response bypasses the buffer
    assign ld_data = data_have ? rdata_buf : data_sram_rdata;

    memory_stage_load_align u_load_align (
        .mem_type (em_q.mem_type),
        .sel      (em_q.alu_result[1:0]),
        .data     (ld_data),
        .result   (aligned)
    );

    assign final_result = (em_q.mem_re && !em_q.ex) ? aligned : em_q.alu_result;

    always_comb begin
        mw              = '0;
        mw.pb           = em_q.pb;
        mw.pc           = em_q.pc;
        mw.final_result = final_result;
        mw.gr_we        = em_q.gr_we;
        mw.dest         = em_q.dest;
        mw.vaddr        = em_q.alu_result;
        mw.ex           = em_q.ex;
        mw.ecode        = em_q.ecode;
        mw.esubcode     = em_q.esubcode;
        mw.csr          = em_q.csr;
    end

    assign MW_BUS   = mw;
    assign Mfwd_BUS = {m_valid && em_q.gr_we && !em_q.ex, em_q.dest, final_result};

`ifdef MEM_PERF_CNT_EN
    // Cycles a valid instruction is held waiting for load data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            load_stall_cnt <= '0;
        end else if (m_valid && !m_ready_go) begin
            load_stall_cnt <= load_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic                clk;
    logic                rstn;
    logic                EM_valid;
    logic [EM_WID-1:0]   EM_BUS;
    logic                M_allowin;
    logic                MW_valid;
    logic [MW_WID-1:0]   MW_BUS;
    logic                W_allowin;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;
    logic                ex_en;
    logic [MFWD_WID-1:0] Mfwd_BUS;
    logic                M_load_pending;
`ifdef MEM_PERF_CNT_EN
    logic [31:0]         load_stall_cnt;
`endif

    mw_bus_t mw;
    assign mw = mw_bus_t'(MW_BUS);

    int n_cmp  = 0;
    int n_fail = 0;

    memory_stage dut (
        .clk               (clk),
        .rstn              (rstn),
        .EM_valid          (EM_valid),
        .EM_BUS            (EM_BUS),
        .M_allowin         (M_allowin),
        .MW_valid          (MW_valid),
        .MW_BUS            (MW_BUS),
        .W_allowin         (W_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ex_en             (ex_en),
        .Mfwd_BUS          (Mfwd_BUS),
`ifdef MEM_PERF_CNT_EN
        .load_stall_cnt    (load_stall_cnt),
`endif
        .M_load_pending    (M_load_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  mtype;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] expect_v;
    } align_vec_t;

    align_vec_t vecs [5] = '{
        '{3'd1, 32'h0000_7002, 32'h8001_0000, 32'hFFFF_8001},
        '{3'd0, 32'h0000_7001, 32'h0000_7F00, 32'h0000_007F},
        '{3'd4, 32'h0000_7003, 32'h80FF_FF7F, 32'h0000_0080},
        '{3'd1, 32'h0000_7000, 32'h0000_7FFF, 32'h0000_7FFF},
        '{3'd3, 32'h0000_7000, 32'hCAFE_F00D, 32'hCAFE_F00D}
    };

    function automatic em_bus_t make_em(input logic [31:0] pc, input logic [31:0] alu,
                                        input logic gr_we, input logic [4:0] dest,
                                        input logic mem_re, input logic [2:0] mtype,
                                        input logic req_sent, input logic ex);
        em_bus_t e;
        e            = '0;
        e.pb         = PB_WID'(pc);
        e.pc         = pc;
        e.alu_result = alu;
        e.gr_we      = gr_we;
        e.dest       = dest;
        e.mem_re     = mem_re;
        e.mem_type   = mtype;
        e.req_sent   = req_sent;
        e.ex         = ex;
        e.ecode      = ex ? 8'h0A : 8'h00;
        e.esubcode   = 1'b0;
        e.csr        = CSR_WID'(pc ^ 32'h5555_AAAA);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge; it is in Memory afterwards
    task automatic enter(input em_bus_t e);
        EM_valid = 1'b1;
        EM_BUS   = EM_WID'(e);
        tick();
        EM_valid = 1'b0;
    endtask

    initial begin
        rstn              = 1'b0;
        EM_valid          = 1'b0;
        EM_BUS            = '0;
        W_allowin         = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        ex_en             = 1'b0;
        #2;
        chk("rst_mw_valid", 64'(MW_valid), 64'd0);
        chk("rst_allowin", 64'(M_allowin), 64'd1);
        chk("rst_mfwd", 64'(Mfwd_BUS), 64'd0);
        chk("rst_pending", 64'(M_load_pending), 64'd0);
        #10;
        rstn = 1'b1;
        tick();

        // ALU op passes straight through
        EM_valid = 1'b1;
        EM_BUS   = EM_WID'(make_em(32'h1C00_0000, 32'h1234, 1'b1, 5'd3, 1'b0, 3'd0, 1'b0, 1'b0));
        #1;
        chk("alu_allowin", 64'(M_allowin), 64'd1);
        tick();
        EM_valid = 1'b0;
        #1;
        chk("alu_mw_valid", 64'(MW_valid), 64'd1);
        chk("alu_final", 64'(mw.final_result), 64'h1234);
        chk("alu_vaddr", 64'(mw.vaddr), 64'h1234);
        chk("alu_pc", 64'(mw.pc), 64'h1C00_0000);
        chk("alu_pb", 64'(mw.pb), 64'h1C00_0000);
        chk("alu_csr", 64'(mw.csr), 64'(32'h1C00_0000 ^ 32'h5555_AAAA));
        chk("alu_mfwd", 64'(Mfwd_BUS), 64'({1'b1, 5'd3, 32'h1234}));
        chk("alu_pending", 64'(M_load_pending), 64'd0);
        tick();
        chk("alu_drained", 64'(MW_valid), 64'd0);

        // LD.B, response two cycles after entry
        enter(make_em(32'h1C00_0004, 32'h0000_1003, 1'b1, 5'd4, 1'b1, 3'd0, 1'b1, 1'b0));
        #1;
        chk("ldb_pending0", 64'(M_load_pending), 64'd1);
        chk("ldb_stall_mw", 64'(MW_valid), 64'd0);
        chk("ldb_stall_allowin", 64'(M_allowin), 64'd0);
        tick();
        chk("ldb_pending1", 64'(M_load_pending), 64'd1);
        chk("ldb_stall_mw1", 64'(MW_valid), 64'd0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FF7F;
        #1;
        chk("ldb_mw_valid", 64'(MW_valid), 64'd1);
        chk("ldb_final", 64'(mw.final_result), 64'hFFFF_FF80);
        chk("ldb_fwd_valid", 64'(Mfwd_BUS[37]), 64'd1);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("ldb_drained", 64'(MW_valid), 64'd0);

        // LD.HU with Writeback stalled: data must be buffered
        enter(make_em(32'h1C00_0008, 32'h0000_2002, 1'b1, 5'd5, 1'b1, 3'd5, 1'b1, 1'b0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBEEF_0000;
        W_allowin         = 1'b0;
        #1;
        chk("ldhu_mw_valid", 64'(MW_valid), 64'd1);
        chk("ldhu_final_bypass", 64'(mw.final_result), 64'h0000_BEEF);
        chk("ldhu_allowin_blk", 64'(M_allowin), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1234_5678;
        #1;
        chk("ldhu_final_buf", 64'(mw.final_result), 64'h0000_BEEF);
        chk("ldhu_pending_buf", 64'(M_load_pending), 64'd0);
        chk("ldhu_mw_hold", 64'(MW_valid), 64'd1);
        tick();
        tick();
        W_allowin = 1'b1;
        #1;
        chk("ldhu_release_allowin", 64'(M_allowin), 64'd1);
        chk("ldhu_release_final", 64'(mw.final_result), 64'h0000_BEEF);
        tick();
        chk("ldhu_drained", 64'(MW_valid), 64'd0);

        // Alignment/extension table, same-cycle response
        for (int i = 0; i < 5; i++) begin
            enter(make_em(32'h1C00_0100, vecs[i].addr, 1'b1, 5'd1, 1'b1, vecs[i].mtype, 1'b1, 1'b0));
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = vecs[i].rdata;
            #1;
            chk($sformatf("align%0d_final", i), 64'(mw.final_result), 64'(vecs[i].expect_v));
            tick();
            data_sram_data_ok = 1'b0;
        end

        // Excepting load: result is alu_result, no forward, no wait
        enter(make_em(32'h1C00_0200, 32'h0000_5000, 1'b1, 5'd8, 1'b1, 3'd2, 1'b0, 1'b1));
        #1;
        chk("ex_mw_valid", 64'(MW_valid), 64'd1);
        chk("ex_final", 64'(mw.final_result), 64'h5000);
        chk("ex_fwd_valid", 64'(Mfwd_BUS[37]), 64'd0);
        chk("ex_flag", 64'(mw.ex), 64'd1);
        chk("ex_ecode", 64'(mw.ecode), 64'h0A);
        tick();

        // Flush while LD.W pending: next response is discarded
        enter(make_em(32'h1C00_0300, 32'h0000_3000, 1'b1, 5'd6, 1'b1, 3'd2, 1'b1, 1'b0));
        #1;
        chk("fl_pending", 64'(M_load_pending), 64'd1);
        ex_en = 1'b1;
        tick();
        ex_en = 1'b0;
        #1;
        chk("fl_mw_valid", 64'(MW_valid), 64'd0);
        chk("fl_allowin", 64'(M_allowin), 64'd1);
        chk("fl_pending_clr", 64'(M_load_pending), 64'd0);
        enter(make_em(32'h1C00_0304, 32'h0000_3004, 1'b1, 5'd7, 1'b1, 3'd2, 1'b1, 1'b0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("fl_discard_mw", 64'(MW_valid), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk("fl_after_discard_mw", 64'(MW_valid), 64'd0);
        chk("fl_after_discard_pend", 64'(M_load_pending), 64'd1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0005;
        #1;
        chk("fl_own_mw", 64'(MW_valid), 64'd1);
        chk("fl_own_final", 64'(mw.final_result), 64'h5);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush coincident with response: nothing left to discard
        enter(make_em(32'h1C00_0400, 32'h0000_4000, 1'b1, 5'd9, 1'b1, 3'd2, 1'b1, 1'b0));
        ex_en             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA_5555;
        tick();
        ex_en             = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        chk("co_mw_valid", 64'(MW_valid), 64'd0);
        chk("co_pending", 64'(M_load_pending), 64'd0);
        enter(make_em(32'h1C00_0404, 32'h0000_4000, 1'b1, 5'd9, 1'b1, 3'd4, 1'b1, 1'b0));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0077;
        #1;
        chk("co_next_mw", 64'(MW_valid), 64'd1);
        chk("co_next_final", 64'(mw.final_result), 64'h77);
        tick();
        data_sram_data_ok = 1'b0;

        // Asynchronous reset mid-load with a discard outstanding
        enter(make_em(32'h1C00_0500, 32'h0000_5000, 1'b1, 5'd2, 1'b1, 3'd2, 1'b1, 1'b0));
        ex_en = 1'b1;
        tick();
        ex_en = 1'b0;
        enter(make_em(32'h1C00_0504, 32'h0000_5004, 1'b1, 5'd2, 1'b1, 3'd2, 1'b1, 1'b0));
        #1;
        chk("ar_pending_before", 64'(M_load_pending), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_mw_valid", 64'(MW_valid), 64'd0);
        chk("ar_pending", 64'(M_load_pending), 64'd0);
        chk("ar_allowin", 64'(M_allowin), 64'd1);
        chk("ar_mfwd", 64'(Mfwd_BUS), 64'd0);
        #1;
        rstn = 1'b1;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hFFFF_FFFF;
        #1;
        chk("ar_stray_mw", 64'(MW_valid), 64'd0);
        tick();
        data_sram_data_ok = 1'b0;
        enter(make_em(32'h1C00_0600, 32'h0000_6000, 1'b1, 5'd10, 1'b1, 3'd2, 1'b1, 1'b0));
        #1;
        chk("ar_new_pending", 64'(M_load_pending), 64'd1);
        chk("ar_new_wait", 64'(MW_valid), 64'd0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0099;
        #1;
        chk("ar_new_mw", 64'(MW_valid), 64'd1);
        chk("ar_new_final", 64'(mw.final_result), 64'h99);
        tick();
        data_sram_data_ok = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
